// File: rtl/store_buffer.sv
// In-order store buffer between the core load/store path and a byte-addressed data RAM.
// Stores queue in a circular FIFO and drain one per cycle; loads take the port unless they overlap a queued store.
module store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [1:0]               ld_size,
    input  logic                     ld_unsigned,
    output logic [31:0]              ld_data,
    output logic                     ld_stall,
    output logic                     sb_empty,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write_enable,
    output logic [31:0]              ram_din,
    input  logic [31:0]              ram_dout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AX_W  = ADDRESS_WIDTH + 1;

    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [31:0]              data_mem [DEPTH];
    logic [1:0]               size_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic accept, load_go, drain;
    logic [DEPTH-1:0] hit;

    // Byte span of an access; size 11 behaves as a word.
    function automatic logic [AX_W-1:0] span_bytes(input logic [1:0] size);
        case (size)
            2'b00:   span_bytes = AX_W'(1);
            2'b01:   span_bytes = AX_W'(2);
            default: span_bytes = AX_W'(4);
        endcase
    endfunction

    assign st_ready = (count_reg != CNT_W'(DEPTH));
    assign sb_empty = (count_reg == '0);
    assign accept   = st_valid && st_ready;
    assign ld_stall = ld_valid && (|hit);
    assign load_go  = ld_valid && !ld_stall;
    assign drain    = !load_go && (count_reg != '0);

    // Overlap test against every occupied slot; math is one bit wider so a+nb cannot wrap.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
            logic [PTR_W-1:0] offset;
            logic             occupied;
            logic [AX_W-1:0]  ent_lo, ld_lo;
            assign offset   = PTR_W'(gi) - head_reg;
            assign occupied = ({1'b0, offset} < count_reg);
            assign ent_lo   = {1'b0, addr_mem[gi]};
            assign ld_lo    = {1'b0, ld_addr};
            assign hit[gi]  = occupied
                              && (ent_lo < ld_lo + span_bytes(ld_size))
                              && (ld_lo < ent_lo + span_bytes(size_mem[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (accept) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (drain) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (accept && !drain) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (drain && !accept) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Entry payload needs no reset: occupancy is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem[tail_reg] <= st_addr;
            data_mem[tail_reg] <= st_data;
            size_mem[tail_reg] <= st_size;
        end
    end

    always_comb begin
        ram_address      = '0;
        ram_write_enable = 1'b0;
        if (load_go) begin
            ram_address = ld_addr;
        end else if (count_reg != '0) begin
            ram_address      = addr_mem[head_reg];
            ram_write_enable = !rst;
        end
    end

    // Sub-word drains merge with the bytes currently at head.addr so neighbours survive the 4-byte write.
    always_comb begin
        ram_din = data_mem[head_reg];
        case (size_mem[head_reg])
            2'b00:   ram_din = {ram_dout[31:8], data_mem[head_reg][7:0]};
            2'b01:   ram_din = {ram_dout[31:16], data_mem[head_reg][15:0]};
            default: ram_din = data_mem[head_reg];
        endcase
    end

    always_comb begin
        ld_data = ram_dout;
        case (ld_size)
            2'b00:   ld_data = {{24{!ld_unsigned && ram_dout[7]}}, ram_dout[7:0]};
            2'b01:   ld_data = {{16{!ld_unsigned && ram_dout[15]}}, ram_dout[15:0]};
            default: ld_data = ram_dout;
        endcase
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a little-endian byte RAM model covering 0x10000-0x101FF.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        sb_empty;
    logic [31:0] ram_address;
    logic        ram_write_enable;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:511];

    always #5 clk = ~clk;

    store_buffer #(.ADDRESS_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .ld_data(ld_data), .ld_stall(ld_stall), .sb_empty(sb_empty),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] i;
        i = a - 32'h10000;
        if (a >= 32'h10000 && i <= 32'd508)
            rd = {mem[i+3], mem[i+2], mem[i+1], mem[i]};
        else
            rd = 32'h0;
    endfunction

    assign ram_dout = rd(ram_address);

    always @(posedge clk) begin
        if (ram_write_enable && ram_address >= 32'h10000 && ram_address - 32'h10000 <= 32'd508) begin
            mem[ram_address - 32'h10000 + 0] <= ram_din[7:0];
            mem[ram_address - 32'h10000 + 1] <= ram_din[15:8];
            mem[ram_address - 32'h10000 + 2] <= ram_din[23:16];
            mem[ram_address - 32'h10000 + 3] <= ram_din[31:24];
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
        $display("[TB] t=%0t %s observed=0x%08h expected=0x%08h", $time, name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[4] = 8'h44; mem[5] = 8'h33; mem[6] = 8'h22; mem[7] = 8'h11;
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b10;
        ld_valid = 1'b0; ld_addr = '0; ld_size = 2'b10; ld_unsigned = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("reset_st_ready", {31'd0, st_ready}, 32'd1);
        check("reset_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("reset_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("reset_we", {31'd0, ram_write_enable}, 32'd0);

        // Word store drains the cycle after acceptance
        store(32'h10000, 32'hDEADBEEF, 2'b10);
        step();
        st_valid = 1'b0;
        #1;
        check("sw_we", {31'd0, ram_write_enable}, 32'd1);
        check("sw_addr", ram_address, 32'h10000);
        check("sw_din", ram_din, 32'hDEADBEEF);
        check("sw_not_empty", {31'd0, sb_empty}, 32'd0);
        step();
        check("sw_empty_after", {31'd0, sb_empty}, 32'd1);
        ld_valid = 1'b1; ld_addr = 32'h10000; ld_size = 2'b10;
        #1;
        check("lw_data", ld_data, 32'hDEADBEEF);
        check("lw_addr", ram_address, 32'h10000);
        ld_valid = 1'b0;

        // Byte store merges with existing neighbours
        store(32'h10004, 32'h000000AB, 2'b00);
        step();
        st_valid = 1'b0;
        #1;
        check("sb_din_merge", ram_din, 32'h112233AB);
        step();
        ld_valid = 1'b1; ld_addr = 32'h10004; ld_size = 2'b00; ld_unsigned = 1'b1;
        #1;
        check("lbu_data", ld_data, 32'h000000AB);
        ld_unsigned = 1'b0;
        #1;
        check("lb_data", ld_data, 32'hFFFFFFAB);

        // Held non-overlapping load blocks draining while the buffer fills
        ld_addr = 32'h10100; ld_size = 2'b10;
        for (int i = 0; i < 4; i++) begin
            store(32'h10010 + 32'(4 * i), 32'(i + 1), 2'b10);
            #1;
            check("fill_no_write", {31'd0, ram_write_enable}, 32'd0);
            step();
        end
        st_valid = 1'b0;
        #1;
        check("fill_st_ready", {31'd0, st_ready}, 32'd0);
        check("fill_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("fill_no_write_full", {31'd0, ram_write_enable}, 32'd0);
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("order_we", {31'd0, ram_write_enable}, 32'd1);
            check("order_addr", ram_address, 32'h10010 + 32'(4 * i));
            check("order_din", ram_din, 32'(i + 1));
            step();
        end
        check("order_empty", {31'd0, sb_empty}, 32'd1);

        // Overlapping load stalls until the half store drains
        store(32'h10002, 32'h0000BEEF, 2'b01);
        step();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h10000; ld_size = 2'b10;
        #1;
        check("ovl_stall", {31'd0, ld_stall}, 32'd1);
        check("ovl_drain_we", {31'd0, ram_write_enable}, 32'd1);
        check("ovl_drain_din", ram_din, 32'h33ABBEEF);
        step();
        check("ovl_stall_drop", {31'd0, ld_stall}, 32'd0);
        check("ovl_ld_data", ld_data, 32'hBEEFBEEF);
        check("ovl_no_write", {31'd0, ram_write_enable}, 32'd0);

        // Full buffer: accept resumes after the first drain, then accept and drain overlap
        ld_addr = 32'h10100;
        for (int i = 0; i < 4; i++) begin
            store(32'h10020 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
            step();
        end
        ld_valid = 1'b0;
        store(32'h10030, 32'hA4, 2'b10);
        #1;
        check("full_st_ready", {31'd0, st_ready}, 32'd0);
        check("full_drain0", ram_din, 32'hA0);
        step();
        check("full_ready_after", {31'd0, st_ready}, 32'd1);
        check("full_drain1", ram_din, 32'hA1);
        step();
        store(32'h10034, 32'hA5, 2'b10);
        #1;
        check("conc_ready", {31'd0, st_ready}, 32'd1);
        check("conc_drain2", ram_din, 32'hA2);
        step();
        st_valid = 1'b0;
        #1;
        check("conc_drain3", ram_din, 32'hA3);
        step();
        check("conc_addr4", ram_address, 32'h10030);
        check("conc_drain4", ram_din, 32'hA4);
        step();
        check("conc_addr5", ram_address, 32'h10034);
        check("conc_drain5", ram_din, 32'hA5);
        step();
        check("conc_empty", {31'd0, sb_empty}, 32'd1);

        // Reset with three queued stores and a stalled load
        ld_valid = 1'b1; ld_addr = 32'h10100;
        for (int i = 0; i < 3; i++) begin
            store(32'h10040 + 32'(4 * i), 32'hC0 + 32'(i), 2'b10);
            step();
        end
        st_valid = 1'b0;
        ld_addr = 32'h10044;
        #1;
        check("rst_pre_stall", {31'd0, ld_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_cycle_no_write", {31'd0, ram_write_enable}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("rst_no_write", {31'd0, ram_write_enable}, 32'd0);
        ld_addr = 32'h10040;
        #1;
        check("rst_mem_untouched", ld_data, 32'h00000000);
        ld_valid = 1'b0;
        step();
        check("rst_idle_we", {31'd0, ram_write_enable}, 32'd0);
        check("rst_idle_addr", ram_address, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store buffer between the single-cycle core's load/store path and the byte-addressed data RAM (32-bit data port, combinational read, write on posedge clk).
- Queues byte, half and word stores and drains them one per cycle when the core is not loading.
- Sub-word stores drain as read-modify-write so the RAM's 4-byte write never corrupts neighbouring bytes.
- Loads get priority on the RAM port, are sign/zero-extended here, and stall while any queued store overlaps them.

Parameters:
- ADDRESS_WIDTH, 32: width of all byte addresses.
- DEPTH, 4: number of store entries; power of two, >=2.

Ports:
- clk  in  1  clock; the block uses this single clock.
- rst  in  1  reset; synchronous, active-high.
- st_valid  in  1  core presents a store.
- st_addr  in  ADDRESS_WIDTH  store byte address; any alignment.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- st_ready  out  1  entry free; store accepted when st_valid & st_ready.
- ld_valid  in  1  core presents a load.
- ld_addr  in  ADDRESS_WIDTH  load byte address.
- ld_size  in  2  same encoding as st_size.
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- ld_data  out  32  extended load result; combinational.
- ld_stall  out  1  load overlaps a queued store; core holds the load.
- sb_empty  out  1  no entries queued (fence/halt condition).
- ram_address  out  ADDRESS_WIDTH  RAM address.
- ram_write_enable  out  1  RAM write strobe.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data: bytes addr+3..addr.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, size}, with head pointer, tail pointer and count.
- Pointers wrap modulo DEPTH.
- Reset: count = head = tail = 0; entry contents don't-care.
- Outputs after reset: st_ready = 1, sb_empty = 1, ld_stall = 0, ram_write_enable = 0.
- Reset asserted mid-drain or mid-stall discards all queued stores; no RAM write occurs in the reset cycle.
- Accept:
  - st_ready = (count != DEPTH), derived from registered count only.
  - No same-cycle bypass when full, even if draining.
  - Accepted store is written at tail on posedge; tail++.
- Overlap:
  - Entry spans [a, a+nb-1] and the load spans [l, l+lb-1], where nb and lb are 1/2/4 bytes.
  - Overlap = (a < l+lb) && (l < a+nb), computed over all valid entries.
  - ld_stall = ld_valid && any overlap; combinational.
- Port arbitration, each cycle:
  - If ld_valid && !ld_stall: ram_address = ld_addr, ram_write_enable = 0, no drain.
  - Otherwise, if count > 0: drain head. ram_address = head.addr, ram_write_enable = 1, head++ on posedge.
  - Otherwise the port is idle: ram_write_enable = 0, ram_address = 0.
- Drain merge, using ram_dout read from head.addr in the same cycle:
  - byte: ram_din = {ram_dout[31:8], data[7:0]}.
  - half: ram_din = {ram_dout[31:16], data[15:0]}.
  - word: ram_din = data.
- Simultaneous accept and drain: count unchanged, both pointers advance. Stores drain strictly in acceptance order.
- A stalled load lets draining proceed; ld_stall drops combinationally once the last overlapping entry has drained.
- ld_data:
  - byte: ram_dout[7:0] extended.
  - half: ram_dout[15:0] extended.
  - word: ram_dout.
  - Value is don't-care while ld_stall = 1.
- sb_empty = (count == 0).
- Address range checking and address arithmetic overflow beyond ADDRESS_WIDTH are outside this block.

Test Plan:
- Reset, then store word 0xDEADBEEF @0x10000 with ld_valid = 0 -> next cycle ram_write_enable = 1, ram_address = 0x10000, ram_din = 0xDEADBEEF; sb_empty = 1 one cycle later.
- RAM @0x10004 holds 0x11223344; store byte 0xAB @0x10004 -> ram_din = 0x112233AB. Then lbu @0x10004 returns 0x000000AB; lb returns 0xFFFFFFAB.
- Hold ld_valid = 1 to a non-overlapping address (0x10100) while 4 stores are issued back-to-back:
  - st_ready = 0 after the 4th store.
  - No RAM writes occur while the load is held.
  - After ld_valid drops, 4 consecutive drains in order.
- Queue half 0xBEEF @0x10002, then lw @0x10000:
  - ld_stall = 1 until the drain cycle.
  - Next cycle ld_stall = 0 and ld_data reflects 0xBEEF in bits [31:16].
- Full buffer with no load: st_valid held -> st_ready = 1 in the cycle after the first drain; accept and drain then run concurrently with count stable at DEPTH-1.
- Assert rst with 3 entries queued and a load stalled -> next cycle sb_empty = 1, ld_stall = 0, no further RAM writes.
